// File: rtl/map_latch_chr.sv
// CPU-written PRG/CHR-page mapper with CHR bank latched from PPU
// nametable fetches; all control paths sampled in the clk domain.
module map_latch_chr #(
  parameter int PRG_BITS       = 2,
  parameter int CHR_PAGE_BITS  = 1,
  parameter int CHR_LATCH_BITS = 2,
  parameter int LATCH_LSB      = 8,
  parameter int PA13_DLY       = 3,
  parameter bit BUS_CF         = 1'b0,
  parameter bit FIX_UPPER      = 1'b1,
  parameter logic [7:0] MAP_IDX = 8'd96
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_m2,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_rw,
  input  logic [7:0]  prg_do,
  input  logic [13:0] ppu_addr,
  input  logic        ppu_oe_n,
  input  logic        ppu_we_n,
  input  logic        mir_v,
  input  logic        sst_act,
  input  logic        sst_we,
  input  logic [7:0]  sst_addr,
  input  logic [7:0]  sst_dato,
  output logic [7:0]  sst_di,
  output logic        prg_ce,
  output logic [15+PRG_BITS-1:0] prg_addr,
  output logic [12+CHR_LATCH_BITS+CHR_PAGE_BITS-1:0] chr_addr,
  output logic        ciram_a10,
  output logic        ciram_ce
);

  localparam int CW = PRG_BITS + CHR_PAGE_BITS;
  localparam int LW = CHR_LATCH_BITS;

  if (CW > 8 || LW > 8 || PA13_DLY < 1) begin : g_bad_cfg
    $error("map_latch_chr: illegal parameter set");
  end

  logic [1:0]         m2_s_q;
  logic               m2_p_q;
  logic               a15_q;
  logic               rw_q;
  logic [CW-1:0]      wd_q;
  logic [PA13_DLY:0]  hist_q;
  logic [PRG_BITS-1:0]      prg_q, prg_d;
  logic [CHR_PAGE_BITS-1:0] page_q, page_d;
  logic [LW-1:0]            latch_q, latch_d;

  logic [7:0] wdata;
  logic       m2_fall;
  logic       pa13_rise;
  logic [LW-1:0] bank;
  logic       unused_ok;

  assign wdata     = BUS_CF ? (cpu_data & prg_do) : cpu_data;
  assign m2_fall   = m2_p_q & ~m2_s_q[1];
  assign pa13_rise = ~hist_q[PA13_DLY] & hist_q[PA13_DLY-1];
  assign unused_ok = ^{wdata, sst_dato};

  // M2 sync, bus sampling while M2 high, PA13 history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_s_q <= '0;
      m2_p_q <= 1'b0;
      a15_q  <= 1'b0;
      rw_q   <= 1'b1;
      wd_q   <= '0;
      hist_q <= '1;
    end else begin
      m2_s_q <= {m2_s_q[0], cpu_m2};
      m2_p_q <= m2_s_q[1];
      if (m2_s_q[1]) begin
        a15_q <= cpu_addr[15];
        rw_q  <= cpu_rw;
        wd_q  <= wdata[CW-1:0];
      end
      hist_q <= {hist_q[PA13_DLY-1:0], ppu_addr[13]};
    end
  end

  // Mapper register updates; save-state writes win on collision
  always_comb begin
    prg_d   = prg_q;
    page_d  = page_q;
    latch_d = latch_q;
    if (!sst_act) begin
      if (m2_fall && a15_q && !rw_q)
        {page_d, prg_d} = wd_q;
      if (pa13_rise && !ppu_addr[12] && ppu_oe_n && ppu_we_n)
        latch_d = ppu_addr[LATCH_LSB +: LW];
    end
    if (sst_we) begin
      if (sst_addr == 8'd0)
        {page_d, prg_d} = sst_dato[CW-1:0];
      if (sst_addr == 8'd1)
        latch_d = sst_dato[LW-1:0];
    end
  end

  // Mapper register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prg_q   <= '0;
      page_q  <= '0;
      latch_q <= '0;
    end else begin
      prg_q   <= prg_d;
      page_q  <= page_d;
      latch_q <= latch_d;
    end
  end

  // Save-state readback
  always_comb begin
    sst_di = 8'hFF;
    unique case (sst_addr)
      8'd0:    sst_di = 8'({page_q, prg_q});
      8'd1:    sst_di = 8'(latch_q);
      8'd127:  sst_di = MAP_IDX;
      default: sst_di = 8'hFF;
    endcase
  end

  assign bank      = (FIX_UPPER && ppu_addr[12]) ? '1 : latch_q;
  assign prg_ce    = cpu_addr[15];
  assign prg_addr  = {prg_q, cpu_addr[14:0]};
  assign chr_addr  = {page_q, bank, ppu_addr[11:0]};
  assign ciram_a10 = mir_v ? ppu_addr[10] : ppu_addr[11];
  assign ciram_ce  = ~ppu_addr[13];

endmodule

// File: tb/tb_map_latch_chr.sv
// Directed bench for map_latch_chr: default build plus a
// bus-conflict build sharing the same stimulus.
module tb_map_latch_chr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_m2;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_rw;
  logic [7:0]  prg_do;
  logic [13:0] ppu_addr;
  logic        ppu_oe_n;
  logic        ppu_we_n;
  logic        mir_v;
  logic        sst_act;
  logic        sst_we;
  logic [7:0]  sst_addr;
  logic [7:0]  sst_dato;

  logic [7:0]  sst_di, sst_di_b;
  logic        prg_ce, prg_ce_b;
  logic [16:0] prg_addr, prg_addr_b;
  logic [14:0] chr_addr, chr_addr_b;
  logic        a10, a10_b, ce, ce_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  map_latch_chr u_dut (
    .clk(clk), .rst_n(rst_n), .cpu_m2(cpu_m2),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_rw(cpu_rw), .prg_do(prg_do),
    .ppu_addr(ppu_addr), .ppu_oe_n(ppu_oe_n),
    .ppu_we_n(ppu_we_n), .mir_v(mir_v),
    .sst_act(sst_act), .sst_we(sst_we),
    .sst_addr(sst_addr), .sst_dato(sst_dato),
    .sst_di(sst_di), .prg_ce(prg_ce),
    .prg_addr(prg_addr), .chr_addr(chr_addr),
    .ciram_a10(a10), .ciram_ce(ce)
  );

  map_latch_chr #(.BUS_CF(1'b1)) u_bcf (
    .clk(clk), .rst_n(rst_n), .cpu_m2(cpu_m2),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_rw(cpu_rw), .prg_do(prg_do),
    .ppu_addr(ppu_addr), .ppu_oe_n(ppu_oe_n),
    .ppu_we_n(ppu_we_n), .mir_v(mir_v),
    .sst_act(sst_act), .sst_we(sst_we),
    .sst_addr(sst_addr), .sst_dato(sst_dato),
    .sst_di(sst_di_b), .prg_ce(prg_ce_b),
    .prg_addr(prg_addr_b), .chr_addr(chr_addr_b),
    .ciram_a10(a10_b), .ciram_ce(ce_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sst_rd(input logic [7:0] a,
                        output logic [7:0] v,
                        output logic [7:0] vb);
    sst_addr = a;
    #1;
    v  = sst_di;
    vb = sst_di_b;
    sst_addr = 8'd0;
  endtask

  // M2 pulse; returns 2 clk after M2 fall (one before commit)
  task automatic m2_cyc(input logic [15:0] a,
                        input logic [7:0] d,
                        input logic rw);
    cpu_addr = a;
    cpu_data = d;
    cpu_rw   = rw;
    cpu_m2   = 1'b1;
    tick(4);
    cpu_m2   = 1'b0;
    tick(2);
  endtask

  // Nametable fetch held 8 clk, then PA13 low for 6 clk
  task automatic fetch(input logic [13:0] a, input logic oe_n);
    ppu_addr = a;
    ppu_oe_n = oe_n;
    tick(8);
    ppu_addr = 14'h0000;
    ppu_oe_n = 1'b1;
    tick(6);
  endtask

  logic [7:0] v, vb;

  initial begin
    rst_n = 1'b0; cpu_m2 = 1'b0;
    cpu_addr = 16'h1234; cpu_data = 8'h00;
    cpu_rw = 1'b1; prg_do = 8'hFF;
    ppu_addr = 14'h2300; ppu_oe_n = 1'b1;
    ppu_we_n = 1'b1; mir_v = 1'b0;
    sst_act = 1'b0; sst_we = 1'b0;
    sst_addr = 8'd0; sst_dato = 8'd0;

    // T1 reset with PA13 high across release
    tick(3);
    chk("rst_prg_addr", 32'(prg_addr), 32'h01234);
    rst_n = 1'b1;
    tick(10);
    sst_rd(8'd1, v, vb);
    chk("t1_latch", 32'(v), 32'h00);
    sst_rd(8'd0, v, vb);
    chk("t1_regs", 32'(v), 32'h00);
    cpu_addr = 16'hFFFF;
    #1;
    chk("t1_prg_hi", 32'(prg_addr[16:15]), 32'h0);
    chk("t1_prg_ce", 32'(prg_ce), 32'h1);
    chk("t1_ciram_ce", 32'(ce), 32'h0);
    ppu_addr = 14'h0000;
    tick(6);

    // T2 CPU write and latency
    m2_cyc(16'h8000, 8'h06, 1'b0);
    sst_rd(8'd0, v, vb);
    chk("t2_early", 32'(v), 32'h00);
    tick(1);
    sst_rd(8'd0, v, vb);
    chk("t2_regs", 32'(v), 32'h06);
    chk("t2_regs_bcf", 32'(vb), 32'h06);
    chk("t2_prg_addr", 32'(prg_addr), 32'h10000);
    chk("t2_chr_page", 32'(chr_addr[14]), 32'h1);
    m2_cyc(16'h8000, 8'h01, 1'b1);
    tick(3);
    sst_rd(8'd0, v, vb);
    chk("t2_read_cyc", 32'(v), 32'h06);
    m2_cyc(16'h7FFF, 8'h01, 1'b0);
    tick(3);
    sst_rd(8'd0, v, vb);
    chk("t2_low_addr", 32'(v), 32'h06);

    // T3 bus conflict
    prg_do = 8'h05;
    m2_cyc(16'hC000, 8'h07, 1'b0);
    tick(3);
    prg_do = 8'hFF;
    sst_rd(8'd0, v, vb);
    chk("t3_nobcf", 32'(v), 32'h07);
    chk("t3_bcf", 32'(vb), 32'h05);

    // T4 PPU latch; PA13 held high then retargeted
    ppu_addr = 14'h2300;
    tick(8);
    ppu_addr = 14'h2100;
    tick(4);
    ppu_addr = 14'h0000;
    tick(6);
    chk("t4_latch3", 32'(chr_addr), 32'h7000);
    fetch(14'h2100, 1'b0);
    sst_rd(8'd1, v, vb);
    chk("t4_oe_block", 32'(v), 32'h03);
    fetch(14'h2000, 1'b1);
    sst_rd(8'd1, v, vb);
    chk("t4_latch0", 32'(v), 32'h00);
    fetch(14'h3300, 1'b1);
    sst_rd(8'd1, v, vb);
    chk("t4_a12_block", 32'(v), 32'h00);
    ppu_addr = 14'h1000;
    #1;
    chk("t4_fix_upper", 32'(chr_addr), 32'h7000);
    ppu_addr = 14'h0ABC;
    #1;
    chk("t4_lower", 32'(chr_addr), 32'h4ABC);
    ppu_addr = 14'h0800;
    #1;
    chk("t4_a10_h", 32'(a10), 32'h1);
    chk("t4_ce", 32'(ce), 32'h1);
    mir_v = 1'b1;
    #1;
    chk("t4_a10_v", 32'(a10), 32'h0);
    ppu_addr = 14'h0000;
    tick(2);

    // T5 save state
    sst_act = 1'b1;
    m2_cyc(16'h8000, 8'h03, 1'b0);
    tick(3);
    sst_rd(8'd0, v, vb);
    chk("t5_cpu_frozen", 32'(v), 32'h07);
    fetch(14'h2300, 1'b1);
    sst_rd(8'd1, v, vb);
    chk("t5_ppu_frozen", 32'(v), 32'h00);
    sst_addr = 8'd1; sst_dato = 8'h02; sst_we = 1'b1;
    tick(1);
    sst_addr = 8'd0; sst_dato = 8'h05;
    tick(1);
    sst_we = 1'b0;
    sst_act = 1'b0;
    sst_rd(8'd0, v, vb);
    chk("t5_rd0", 32'(v), 32'h05);
    chk("t5_rd0_bcf", 32'(vb), 32'h05);
    sst_rd(8'd1, v, vb);
    chk("t5_rd1", 32'(v), 32'h02);
    sst_rd(8'd127, v, vb);
    chk("t5_rd127", 32'(v), 32'h60);
    sst_rd(8'd5, v, vb);
    chk("t5_rd5", 32'(v), 32'hFF);

    // T6 reset during an M2-high write
    cpu_addr = 16'h8000; cpu_data = 8'h07;
    cpu_rw = 1'b0; cpu_m2 = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    sst_rd(8'd0, v, vb);
    chk("t6_rst_regs", 32'(v), 32'h00);
    sst_rd(8'd1, v, vb);
    chk("t6_rst_latch", 32'(v), 32'h00);
    tick(1);
    cpu_m2 = 1'b0;
    rst_n = 1'b1;
    tick(8);
    sst_rd(8'd0, v, vb);
    chk("t6_no_commit", 32'(v), 32'h00);
    chk("t6_no_commit_bcf", 32'(vb), 32'h00);
    chk("t6_prg_addr", 32'(prg_addr), 32'h00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
